mmc_cmd_engine: RTL and testbench

Bit-level command-line sequencer for the MMC/SD controller. It serialises a 48-bit command frame (start bit, transmission bit, index, argument, CRC7, end bit) onto the CMD line, one bit per MMC clock-enable strobe. It then waits for and captures the card response, with timeout and optional CRC7 checking. It sits between the register interface and the CMD pad, replacing software bit-banging of the command line.

---
 rtl/mmc_pkg.sv | 41 ++++
 rtl/mmc_crc7.sv | 26 ++
 rtl/mmc_cmd_engine.sv | 228 ++++++++++++++++++++++
 tb/tb_mmc_cmd_engine.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmc_pkg.sv
// mmc_pkg: shared types and constants for the MMC command-line engine.
// Holds the response-type and FSM encodings, the CRC7 polynomial and
// frame lengths, plus the single-bit CRC7 step used by mmc_crc7.
package mmc_pkg;

  typedef enum logic [1:0] {
    RSP_NONE        = 2'd0,
    RSP_SHORT       = 2'd1,
    RSP_SHORT_NOCRC = 2'd2,
    RSP_LONG        = 2'd3
  } rsp_type_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX,
    ST_RELEASE,
    ST_WAIT_RSP,
    ST_RX,
    ST_GAP,
    ST_DONE
  } state_t;

  // x^7 + x^3 + 1 (the x^7 term is implicit)
  localparam logic [6:0] CRC7_POLY = 7'h09;

  localparam int CMD_FRAME_LEN  = 48;
  localparam int SHORT_RSP_LEN  = 48;
  localparam int LONG_RSP_LEN   = 136;
  // lowest frame bit covered by the CRC (bits 7:1 carry the CRC itself)
  localparam int CRC_LO_BIT     = 8;
  // highest long-response bit that enters the CRC
  localparam int LONG_CRC_HI    = 127;

  // advance a CRC7 by one message bit, MSB-first
  function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/mmc_crc7.sv
// mmc_crc7: serial CRC7 accumulator with synchronous clear and bit enable.
module mmc_crc7 import mmc_pkg::*; (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic [6:0] crc_reg;

  // CRC register: clear has priority over accumulating a new bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc_reg <= '0;
    end else if (clr) begin
      crc_reg <= '0;
    end else if (en) begin
      crc_reg <= crc7_next(crc_reg, din);
    end
  end

  assign crc = crc_reg;

endmodule

// File: rtl/mmc_cmd_engine.sv
// mmc_cmd_engine: serialises a 48-bit MMC command onto the CMD line and
// captures the card response (none / short / short-no-CRC / long) with a
// start-bit timeout and optional response CRC7 checking.
// Optional feature macro: MMC_CMD_CRC_CHECK_EN builds the receive CRC7
// checker; without it crc_err stays 0.
module mmc_cmd_engine import mmc_pkg::*; #(
  parameter int RSP_TIMEOUT = 64,
  parameter int GAP_STROBES = 8
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_n_i,
  input  logic         mmc_clk_en,
  input  logic         start,
  input  logic [5:0]   cmd_idx,
  input  logic [31:0]  cmd_arg,
  input  logic [1:0]   rsp_type,
  output logic         busy,
  output logic         done,
  output logic         rsp_timeout,
  output logic         crc_err,
  output logic [127:0] rsp_data,
  output logic         mmc_cmd_o,
  output logic         mmc_cmd_oe,
  input  logic         mmc_cmd_i
);

  state_t       state_reg, state_next;
  logic [7:0]   cnt_reg, cnt_next;
  logic [39:0]  tx_shift_reg, tx_shift_next;
  rsp_type_t    type_reg, type_next;
  logic [127:0] rsp_data_reg, rsp_data_next;
  logic         timeout_reg, timeout_next;
  logic         crc_err_reg, crc_err_next;
  logic         cmd_o_reg, cmd_o_next;
  logic         cmd_oe_reg, cmd_oe_next;

  logic         accept;
  logic [6:0]   tx_crc;
  logic         tx_crc_en;
  logic [2:0]   crc_sel;
  logic         tx_bit;
  logic         crc_mismatch;

  assign accept    = (state_reg == ST_IDLE) && start;
  // the TX CRC covers frame bits 47:8, i.e. while the shift register is emitting
  assign tx_crc_en = (state_reg == ST_TX) && mmc_clk_en && (cnt_reg >= 8'(CRC_LO_BIT));

  mmc_crc7 u_tx_crc (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_n_i),
    .clr   (accept),
    .en    (tx_crc_en),
    .din   (tx_shift_reg[39]),
    .crc   (tx_crc)
  );

  // frame positions 7..1 map onto CRC bits 6..0
  assign crc_sel = cnt_reg[2:0] - 3'd1;

  // select the frame bit for the current TX position (cnt_reg = bit index)
  always_comb begin
    tx_bit = 1'b1;
    if (cnt_reg >= 8'(CRC_LO_BIT)) begin
      tx_bit = tx_shift_reg[39];
    end else if (cnt_reg != 8'd0) begin
      tx_bit = tx_crc[crc_sel];
    end
  end

`ifdef MMC_CMD_CRC_CHECK_EN
  logic [6:0] rx_crc;
  logic       rx_crc_clr;
  logic       rx_crc_en;

  // the start bit is a 0, so clearing on it is the same as feeding it in
  assign rx_crc_clr = accept ||
                      ((state_reg == ST_WAIT_RSP) && mmc_clk_en && !mmc_cmd_i);
  // long responses skip their 8 header bits; short ones never exceed bit 46
  assign rx_crc_en  = (state_reg == ST_RX) && mmc_clk_en &&
                      (cnt_reg >= 8'(CRC_LO_BIT)) && (cnt_reg <= 8'(LONG_CRC_HI));

  mmc_crc7 u_rx_crc (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_n_i),
    .clr   (rx_crc_clr),
    .en    (rx_crc_en),
    .din   (mmc_cmd_i),
    .crc   (rx_crc)
  );

  // checked on the end-bit strobe, when rsp_data[6:0] holds received bits 7:1
  assign crc_mismatch = (rx_crc != rsp_data_reg[6:0]) &&
                        ((type_reg == RSP_SHORT) || (type_reg == RSP_LONG));
`else
  assign crc_mismatch = 1'b0;
`endif

  // next-state and datapath updates; only strobe cycles advance the sequence
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    tx_shift_next = tx_shift_reg;
    type_next     = type_reg;
    rsp_data_next = rsp_data_reg;
    timeout_next  = timeout_reg;
    crc_err_next  = crc_err_reg;
    cmd_o_next    = cmd_o_reg;
    cmd_oe_next   = cmd_oe_reg;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next    = ST_TX;
          cnt_next      = 8'(CMD_FRAME_LEN - 1);
          tx_shift_next = {2'b01, cmd_idx, cmd_arg};
          type_next     = rsp_type_t'(rsp_type);
          rsp_data_next = '0;
          timeout_next  = 1'b0;
          crc_err_next  = 1'b0;
        end
      end

      ST_TX: begin
        if (mmc_clk_en) begin
          cmd_o_next  = tx_bit;
          cmd_oe_next = 1'b1;
          if (cnt_reg >= 8'(CRC_LO_BIT)) begin
            tx_shift_next = {tx_shift_reg[38:0], 1'b0};
          end
          if (cnt_reg == 8'd0) begin
            state_next = ST_RELEASE;
          end else begin
            cnt_next = cnt_reg - 8'd1;
          end
        end
      end

      ST_RELEASE: begin
        if (mmc_clk_en) begin
          cmd_o_next  = 1'b1;
          cmd_oe_next = 1'b0;
          cnt_next    = 8'd0;
          state_next  = (type_reg == RSP_NONE) ? ST_GAP : ST_WAIT_RSP;
        end
      end

      ST_WAIT_RSP: begin
        if (mmc_clk_en) begin
          if (!mmc_cmd_i) begin
            state_next = ST_RX;
            cnt_next   = (type_reg == RSP_LONG) ? 8'(LONG_RSP_LEN - 2)
                                                : 8'(SHORT_RSP_LEN - 2);
          end else if (cnt_reg == 8'(RSP_TIMEOUT - 1)) begin
            timeout_next = 1'b1;
            state_next   = ST_GAP;
            cnt_next     = 8'd0;
          end else begin
            cnt_next = cnt_reg + 8'd1;
          end
        end
      end

      ST_RX: begin
        if (mmc_clk_en) begin
          rsp_data_next = {rsp_data_reg[126:0], mmc_cmd_i};
          if (cnt_reg == 8'd0) begin
            crc_err_next = crc_mismatch;
            state_next   = ST_GAP;
          end else begin
            cnt_next = cnt_reg - 8'd1;
          end
        end
      end

      ST_GAP: begin
        if (mmc_clk_en) begin
          if (cnt_reg == 8'(GAP_STROBES - 1)) begin
            state_next = ST_DONE;
          end else begin
            cnt_next = cnt_reg + 8'd1;
          end
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // state and datapath registers with synchronous active-low reset
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      tx_shift_reg <= '0;
      type_reg     <= RSP_NONE;
      rsp_data_reg <= '0;
      timeout_reg  <= 1'b0;
      crc_err_reg  <= 1'b0;
      cmd_o_reg    <= 1'b1;
      cmd_oe_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      tx_shift_reg <= tx_shift_next;
      type_reg     <= type_next;
      rsp_data_reg <= rsp_data_next;
      timeout_reg  <= timeout_next;
      crc_err_reg  <= crc_err_next;
      cmd_o_reg    <= cmd_o_next;
      cmd_oe_reg   <= cmd_oe_next;
    end
  end

  assign busy        = (state_reg != ST_IDLE);
  assign done        = (state_reg == ST_DONE);
  assign rsp_timeout = timeout_reg;
  assign crc_err     = crc_err_reg;
  assign rsp_data    = rsp_data_reg;
  assign mmc_cmd_o   = cmd_o_reg;
  assign mmc_cmd_oe  = cmd_oe_reg;

endmodule

// File: tb/tb_mmc_cmd_engine.sv
// tb_mmc_cmd_engine: scoreboard bench for mmc_cmd_engine. Commands push their
// expected outcome into a queue; a monitor pops and compares on every done.
// A card model answers on the CMD line; expectations come from a long-division
// CRC7 model and frame-level arithmetic.
module tb_mmc_cmd_engine;

  localparam int RSP_TIMEOUT = 64;
  localparam int GAP_STROBES = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         start = 1'b0;
  logic [5:0]   idx = '0;
  logic [31:0]  arg = '0;
  logic [1:0]   rtype = '0;
  logic         cmd_i = 1'b1;
  logic         busy, done, to, ce, cmd_o, cmd_oe;
  logic [127:0] rsp_data;

  always #5 clk = ~clk;

  mmc_cmd_engine #(.RSP_TIMEOUT(RSP_TIMEOUT), .GAP_STROBES(GAP_STROBES)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .mmc_clk_en(en), .start(start),
    .cmd_idx(idx), .cmd_arg(arg), .rsp_type(rtype), .busy(busy), .done(done),
    .rsp_timeout(to), .crc_err(ce), .rsp_data(rsp_data), .mmc_cmd_o(cmd_o),
    .mmc_cmd_oe(cmd_oe), .mmc_cmd_i(cmd_i)
  );

  typedef struct {
    logic [47:0]  frame;
    logic [127:0] data;
    logic         to;
    logic         ce;
    int           strobes;
  } exp_t;

  typedef struct {
    bit           silent;
    int           delay;
    int           len;
    logic [135:0] frame;
  } card_t;

  exp_t  exp_q[$];
  card_t card_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    done_seen = 0;
  int    n_cmds = 0;
  int    mon_tx_n = 0;
  int    txn_no = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  // CRC7 by modulo-2 long division of msg * x^7 by x^7+x^3+1
  function automatic logic [6:0] crc7_ref(input logic [119:0] msg, input int nbits);
    logic [126:0] r;
    r = {msg, 7'b0};
    for (int i = nbits + 6; i >= 7; i--) begin
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    end
    return r[6:0];
  endfunction

  function automatic logic [135:0] short_frame(input logic [5:0] i, input logic [31:0] a);
    logic [47:0] f;
    f = {2'b00, i, a, 8'h01};
    f[7:1] = crc7_ref(120'(f[47:8]), 40);
    return 136'(f);
  endfunction

  function automatic logic [135:0] long_frame(input logic [119:0] p);
    return {8'h3F, p, crc7_ref(p, 120), 1'b1};
  endfunction

  // random strobe: changes only on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      en = ($urandom_range(0, 2) == 0);
    end
  end

  task automatic wait_strobe();
    do @(posedge clk); while (en !== 1'b1);
    #1;
  endtask

  // card model: after the line is released, idle `delay` strobes then send
  initial begin
    card_t c;
    bit    seen;
    bit    strb;
    int    guard;
    forever begin
      @(negedge clk);
      if (card_q.size() != 0) begin
        c = card_q.pop_front();
        seen = 0;
        guard = 0;
        while (guard < 5000) begin
          @(posedge clk);
          strb = en;
          #1;
          if (cmd_oe) seen = 1;
          else if (seen && strb) break;
          guard++;
        end
        if (!c.silent) begin
          for (int k = 0; k < c.delay; k++) wait_strobe();
          cmd_i = c.frame[c.len-1];
          for (int j = c.len - 1; j >= 0; j--) begin
            wait_strobe();
            cmd_i = (j > 0) ? c.frame[j-1] : 1'b1;
          end
        end
      end
    end
  end

  // monitor: collects driven bits and strobe count, scores each done pulse
  initial begin
    logic [47:0] tx_bits;
    int          strobes;
    logic        busy_prev;
    logic        en_edge;
    exp_t        e;
    tx_bits = '0;
    strobes = 0;
    busy_prev = 1'b0;
    forever begin
      @(posedge clk);
      en_edge = en;
      #1;
      if (!busy_prev) begin
        tx_bits = '0;
        mon_tx_n = 0;
        strobes = 0;
      end
      if (en_edge && busy_prev) begin
        strobes++;
        if (cmd_oe) begin
          tx_bits = {tx_bits[46:0], cmd_o};
          mon_tx_n++;
        end
      end
      if (done) begin
        done_seen++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1, expected no pending command");
        end else begin
          e = exp_q.pop_front();
          txn_no++;
          check("tx_frame", 128'(tx_bits), 128'(e.frame));
          check("tx_bit_count", 128'(mon_tx_n), 128'(48));
          check("done_strobes", 128'(strobes), 128'(e.strobes));
          check("rsp_timeout", 128'(to), 128'(e.to));
          check("crc_err", 128'(ce), 128'(e.ce));
          check("rsp_data", rsp_data, e.data);
          $display("txn %0d: frame=%012h strobes=%0d to=%0b crc_err=%0b rsp_data=%032h",
                   txn_no, tx_bits, strobes, to, ce, rsp_data);
        end
      end
      busy_prev = busy;
    end
  end

  task automatic issue(input logic [5:0] i, input logic [31:0] a, input logic [1:0] t);
    @(negedge clk);
    idx = i;
    arg = a;
    rtype = t;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int cyc;
    cyc = 0;
    while (done_seen < target && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    if (done_seen < target) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected done", cyc);
      summary();
    end
  endtask

  task automatic run_cmd(input logic [5:0] i, input logic [31:0] a, input logic [1:0] t,
                         input bit silent, input int delay, input logic [135:0] rf,
                         input bit poke_busy);
    exp_t        e;
    card_t       c;
    int          len;
    logic [47:0] f;
    f = {2'b01, i, a, 8'h01};
    f[7:1] = crc7_ref(120'(f[47:8]), 40);
    len = (t == 2'd3) ? 136 : 48;
    e.frame = f;
    e.data = '0;
    e.to = 1'b0;
    e.ce = 1'b0;
    if (t == 2'd0) begin
      e.strobes = 48 + 1 + GAP_STROBES;
    end else if (silent) begin
      e.to = 1'b1;
      e.strobes = 48 + 1 + RSP_TIMEOUT + GAP_STROBES;
    end else begin
      // TX + release + idle strobes + start bit + remaining bits + gap
      e.strobes = 48 + 1 + delay + len + GAP_STROBES;
      e.data = (len == 48) ? 128'(rf[46:0]) : rf[127:0];
`ifdef MMC_CMD_CRC_CHECK_EN
      if (t == 2'd1) e.ce = (crc7_ref(120'(rf[47:8]), 40) != rf[7:1]);
      if (t == 2'd3) e.ce = (crc7_ref(rf[127:8], 120) != rf[7:1]);
`endif
    end
    exp_q.push_back(e);
    if (t != 2'd0) begin
      c.silent = silent;
      c.delay = delay;
      c.len = len;
      c.frame = rf;
      card_q.push_back(c);
    end
    issue(i, a, t);
    if (poke_busy) begin
      repeat (20) @(negedge clk);
      check("busy_mid_cmd", 128'(busy), 128'(1));
      idx = 6'h3F;
      arg = 32'hFFFF_FFFF;
      rtype = 2'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    n_cmds++;
    wait_done(n_cmds);
  endtask

  initial begin
    logic [127:0] p;
    logic [135:0] rf;
    logic [1:0]   t;
    bit           silent;
    int           b;
    int           guard;

    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_done", 128'(done), 128'(0));
    check("reset_timeout", 128'(to), 128'(0));
    check("reset_crc_err", 128'(ce), 128'(0));
    check("reset_rsp_data", rsp_data, 128'(0));
    check("reset_cmd_o", 128'(cmd_o), 128'(1));
    check("reset_cmd_oe", 128'(cmd_oe), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // CMD0 and CMD8 without response; a start pulsed mid-CMD8 must be ignored
    run_cmd(6'd0, 32'h0, 2'd0, 0, 0, '0, 0);
    run_cmd(6'd8, 32'h1AA, 2'd0, 0, 0, '0, 1);

    // short response, clean then with argument bit 0 flipped; R3 ignores CRC
    run_cmd(6'd2, 32'h0, 2'd1, 0, 5, 136'h400000000095, 0);
    run_cmd(6'd2, 32'h0, 2'd1, 0, 5, 136'h400000000195, 0);
    run_cmd(6'd41, 32'h0, 2'd2, 0, 5, 136'h400000000195, 0);

    // no start bit: timeout
    run_cmd(6'd17, 32'h1234_5678, 2'd1, 1, 0, '0, 0);

    // long response
    p = {$urandom(), $urandom(), $urandom(), $urandom()};
    run_cmd(6'd9, 32'hABCD_0000, 2'd3, 0, 3, long_frame(p[119:0]), 0);

    // reset in the middle of TX, then a normal command
    issue(6'd24, 32'hDEAD_BEEF, 2'd0);
    guard = 0;
    while (mon_tx_n < 20 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("reached_tx_bit20", 128'(mon_tx_n >= 20), 128'(1));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midtx_reset_oe", 128'(cmd_oe), 128'(0));
    check("midtx_reset_busy", 128'(busy), 128'(0));
    check("midtx_reset_cmd_o", 128'(cmd_o), 128'(1));
    @(negedge clk);
    rst_n = 1'b1;
    run_cmd(6'd55, 32'h0000_0001, 2'd1, 0, 2, short_frame(6'd55, 32'h0000_0120), 0);

    // randomized commands and card behaviour
    for (int n = 0; n < 10; n++) begin
      t = 2'($urandom_range(0, 3));
      silent = ($urandom_range(0, 4) == 0);
      p = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (t == 2'd3) rf = long_frame(p[119:0]);
      else rf = short_frame(p[5:0], p[37:6]);
      if ($urandom_range(0, 2) == 0) begin
        b = (t == 2'd3) ? int'($urandom_range(8, 127)) : int'($urandom_range(8, 46));
        rf[b] = ~rf[b];
      end
      run_cmd(6'($urandom()), $urandom(), t, silent, int'($urandom_range(0, 10)), rf, 0);
    end

    repeat (5) @(negedge clk);
    check("queue_drained", 128'(exp_q.size()), 128'(0));
    summary();
  end

endmodule
